// File: rtl/mem_port_arbiter_pkg.sv
// Shared RISC-V ISA header: base opcodes, load/store funct3 codes and the
// memory-port arbiter state encoding and default limits.
package mem_port_arbiter_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int ARB_TIMEOUT_DEF         = 255;
   localparam int ARB_MAX_DATA_STREAK_DEF = 2;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_FETCH = 2'd1,
      ARB_DATA  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_arb_priority.sv
// Grant decision for the shared memory port: data first, unless a waiting
// fetch has already watched a full streak of data grants go by.
module arb_priority (
   input  logic f_req,
   input  logic d_req,
   input  logic streak_full,
   output logic grant_data
);

   assign grant_data = d_req & ~(f_req & streak_full);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory port, with
// a starvation limit for fetch and a per-access m_ack timeout.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int XLEN            = 32,
   parameter int MAX_DATA_STREAK = ARB_MAX_DATA_STREAK_DEF,
   parameter int TIMEOUT         = ARB_TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            f_req,
   input  logic [XLEN-1:0] f_addr,
   output logic            f_done,
   output logic            f_err,
   output logic [XLEN-1:0] f_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [3:0]      d_wstrb,
   output logic            d_done,
   output logic            d_err,
   output logic [XLEN-1:0] d_rdata,
   output logic            m_req,
   output logic            m_we,
   output logic [XLEN-1:0] m_addr,
   output logic [XLEN-1:0] m_wdata,
   output logic [3:0]      m_wstrb,
   input  logic            m_ack,
   input  logic [XLEN-1:0] m_rdata,
   output logic            busy
);

   // state  | meaning
   // IDLE   | port free; requests arbitrated at every edge
   // FETCH  | fetch granted; first cycle raises m_req, then waits for m_ack
   // DATA   | data granted; first cycle raises m_req, then waits for m_ack

   localparam logic [7:0] STREAK_MAX = 8'(MAX_DATA_STREAK);
   localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

   arb_state_e      state_q, state_d;
   logic            m_req_q, m_req_d;
   logic            m_we_q, m_we_d;
   logic [XLEN-1:0] m_addr_q, m_addr_d;
   logic [XLEN-1:0] m_wdata_q, m_wdata_d;
   logic [3:0]      m_wstrb_q, m_wstrb_d;
   logic            f_done_q, f_done_d, f_err_q, f_err_d;
   logic [XLEN-1:0] f_rdata_q, f_rdata_d;
   logic            d_done_q, d_done_d, d_err_q, d_err_d;
   logic [XLEN-1:0] d_rdata_q, d_rdata_d;
   logic            busy_q, busy_d;
   logic [7:0]      streak_q, streak_d;
   logic [7:0]      wait_q, wait_d;
   logic            grant_data;

   arb_priority u_arb_priority (
      .f_req       (f_req),
      .d_req       (d_req),
      .streak_full (streak_q == STREAK_MAX),
      .grant_data  (grant_data)
   );

   always_comb begin
      state_d   = state_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_wstrb_d = m_wstrb_q;
      f_done_d  = 1'b0;
      f_err_d   = 1'b0;
      f_rdata_d = f_rdata_q;
      d_done_d  = 1'b0;
      d_err_d   = 1'b0;
      d_rdata_d = d_rdata_q;
      streak_d  = streak_q;
      wait_d    = wait_q;
      case (state_q)
         ARB_IDLE: begin
            if (!f_req) streak_d = '0;
            if (grant_data) begin
               state_d   = ARB_DATA;
               m_we_d    = d_we;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
               m_wstrb_d = d_wstrb;
               if (f_req) streak_d = streak_q + 8'd1;
            end else if (f_req) begin
               state_d   = ARB_FETCH;
               m_we_d    = 1'b0;
               m_addr_d  = f_addr;
               m_wdata_d = '0;
               m_wstrb_d = '0;
               streak_d  = '0;
            end
         end
         default: begin
            if (!m_req_q) begin
               m_req_d = 1'b1;
               wait_d  = '0;
            end else if (m_ack || (wait_q == WAIT_LAST)) begin
               // an ack in the last allowed cycle still wins over the timeout
               state_d = ARB_IDLE;
               m_req_d = 1'b0;
               wait_d  = '0;
               if (state_q == ARB_FETCH) begin
                  f_done_d  = 1'b1;
                  f_err_d   = ~m_ack;
                  f_rdata_d = m_ack ? m_rdata : '0;
               end else begin
                  d_done_d  = 1'b1;
                  d_err_d   = ~m_ack;
                  d_rdata_d = (m_ack && !m_we_q) ? m_rdata : '0;
               end
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
      endcase
      busy_d = (state_d != ARB_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_wstrb_q <= '0;
         f_done_q  <= 1'b0;
         f_err_q   <= 1'b0;
         f_rdata_q <= '0;
         d_done_q  <= 1'b0;
         d_err_q   <= 1'b0;
         d_rdata_q <= '0;
         busy_q    <= 1'b0;
         streak_q  <= '0;
         wait_q    <= '0;
      end else begin
         state_q   <= state_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_wstrb_q <= m_wstrb_d;
         f_done_q  <= f_done_d;
         f_err_q   <= f_err_d;
         f_rdata_q <= f_rdata_d;
         d_done_q  <= d_done_d;
         d_err_q   <= d_err_d;
         d_rdata_q <= d_rdata_d;
         busy_q    <= busy_d;
         streak_q  <= streak_d;
         wait_q    <= wait_d;
      end
   end

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_wstrb = m_wstrb_q;
   assign f_done  = f_done_q;
   assign f_err   = f_err_q;
   assign f_rdata = f_rdata_q;
   assign d_done  = d_done_q;
   assign d_err   = d_err_q;
   assign d_rdata = d_rdata_q;
   assign busy    = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter XLEN, default 32, sets the address and data width.
REQ-002 Parameter MAX_DATA_STREAK, default 2, is the maximum number of consecutive data grants allowed while fetch waits.
REQ-003 Parameter TIMEOUT, default 255, range 1..255, is the number of cycles a memory access may wait for m_ack before it is aborted.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 f_req  in  1  instruction-fetch request, held until f_done.
REQ-007 f_addr  in  XLEN  fetch address, held stable while f_req is high.
REQ-008 f_done / f_err / f_rdata  out  1/1/XLEN  fetch completion pulse, abort flag and fetched word.
REQ-009 d_req, d_we, d_addr, d_wdata, d_wstrb  in  1/1/XLEN/XLEN/4  data request, write enable, address, store data and byte strobes, held until d_done.
REQ-010 d_done / d_err / d_rdata  out  1/1/XLEN  data completion pulse, abort flag and load data.
REQ-011 m_req, m_we, m_addr, m_wdata, m_wstrb  out  1/1/XLEN/XLEN/4  shared memory port request and its attributes.
REQ-012 m_ack / m_rdata  in  1/XLEN  memory acknowledge and read data, valid in the m_ack cycle.
REQ-013 busy  out  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have three states, IDLE, FETCH and DATA; all outputs are registered.
REQ-015 In IDLE, any request sampled at an edge SHALL move the FSM to FETCH or DATA and latch the winner's address, we, wdata and wstrb into the m_* registers.
REQ-016 m_req SHALL be high from the edge after the grant until the edge at which m_ack is sampled high, with every m_* signal held stable throughout.
REQ-017 When m_ack is sampled high, the FSM SHALL return to IDLE, drop m_req, pulse the granted requester's done for exactly one cycle and register m_rdata into its rdata.
REQ-018 Minimum latency SHALL be 2 cycles from the request edge to done high (m_ack high in the first m_req cycle).
REQ-019 For a store (d_we=1), d_rdata SHALL be 0 at d_done.
REQ-020 Arbitration: with both requests high, data SHALL win unless the streak counter equals MAX_DATA_STREAK, in which case fetch SHALL win.
REQ-021 The streak counter SHALL increment on each data grant made while f_req is high, and clear on any fetch grant or on any IDLE edge with f_req low.
REQ-022 A requester that keeps req high during its done cycle SHALL be treated as making a new request and be arbitrated at the next edge; done-to-next-m_req therefore takes 2 cycles.
REQ-023 m_ack SHALL be ignored in IDLE.
REQ-024 A wait counter SHALL count the m_req cycles; on reaching TIMEOUT without m_ack, the access SHALL abort: m_req drops, done and err pulse together, rdata is 0, FSM returns to IDLE.
REQ-025 m_ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-026 The err outputs SHALL be low whenever the corresponding done is low.

Reset
REQ-027 While rst is high: state IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, m_wstrb=0, f_done=f_err=d_done=d_err=0, f_rdata=d_rdata=0, busy=0, streak and wait counters 0.
REQ-028 Reset during FETCH or DATA SHALL drop m_req immediately and produce no done pulse; the interrupted request is lost.

Structure
REQ-029 The FSM state encodings and the TIMEOUT and MAX_DATA_STREAK defaults SHALL live in the shared RISC-V ISA header alongside the opcode and funct3 constants.
REQ-030 The grant decision SHALL be one combinational sub-module, arb_priority (inputs: f_req, d_req, streak_full; output: grant_data); everything else is in mem_port_arbiter.

Verification
REQ-031 Single fetch: f_req with f_addr=0x100, m_ack one cycle after m_req with m_rdata=0x00000013 -> m_addr=0x100, f_done pulse with f_rdata=0x13, total 3 cycles.
REQ-032 Simultaneous: f_req and d_req held continuously, m_ack immediate -> grant order D,D,F,D,D,F with MAX_DATA_STREAK=2.
REQ-033 Store: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF -> m_* match exactly, d_done with d_rdata=0, f_* outputs untouched.
REQ-034 Timeout: TIMEOUT=4, m_ack never asserted -> m_req high exactly 4 cycles, then d_done=d_err=1 for one cycle; m_ack in cycle 4 -> success with d_err=0.
REQ-035 Reset mid-access: rst asserted in the second m_req cycle -> m_req low before the next edge, no done pulse; after release, IDLE with all outputs 0.
